// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for the MIPS MEM stage: IDLE -> BUSY -> DONE access FSM.
// Optional DMEM_ERR_EN adds MemErr for misaligned or read+write requests.
module dmem_responder #(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] MemAdr,
   input  logic [31:0] MemWriteD,
   output logic [31:0] MemReadD,
   output logic        MemStall,
   output logic        MemDone
`ifdef DMEM_ERR_EN
   ,
   output logic        MemErr
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

   logic [1:0]        state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              op_write_reg;
   logic [ADDR_W-1:0] idx_reg;
   logic [31:0]       data_reg;
   logic [31:0]       rdata_reg;

   logic [31:0]       mem [DEPTH];

   logic              req, idle, enter_done;
   logic              cur_write, cur_err, req_err;
   logic [ADDR_W-1:0] cur_idx;
   logic [31:0]       cur_data;
   logic              mem_we, rd_en;
   logic              unused_adr;

   assign req  = MemRead | MemWrite;
   assign idle = (state_reg == IDLE);

   // With zero wait states the array is accessed on the same edge that accepts the
   // request, so the live inputs stand in for the latched copies while idle.
   assign cur_write = idle ? MemWrite : op_write_reg;
   assign cur_idx   = idle ? MemAdr[ADDR_W+1:2] : idx_reg;
   assign cur_data  = idle ? MemWriteD : data_reg;

`ifdef DMEM_ERR_EN
   logic err_reg;
   assign req_err    = (MemAdr[1:0] != 2'b00) | (MemRead & MemWrite);
   assign cur_err    = idle ? req_err : err_reg;
   assign MemErr     = (state_reg == DONE) & err_reg;
   assign unused_adr = ^MemAdr[31:ADDR_W+2];
`else
   assign req_err    = 1'b0;
   assign cur_err    = req_err;
   assign unused_adr = ^{MemAdr[31:ADDR_W+2], MemAdr[1:0]};
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               cnt_next   = WAIT_INIT;
               state_next = NO_WAIT ? DONE : BUSY;
            end
         end
         BUSY: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign enter_done = (state_reg != DONE) && (state_next == DONE);
   assign mem_we     = enter_done & cur_write & ~cur_err;
   assign rd_en      = enter_done & ~cur_write & ~cur_err;

   assign MemStall = (idle & req) | (state_reg == BUSY);
   assign MemDone  = (state_reg == DONE);
   assign MemReadD = rdata_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         op_write_reg <= 1'b0;
         idx_reg      <= '0;
         data_reg     <= 32'd0;
         rdata_reg    <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (idle && req) begin
            op_write_reg <= MemWrite;
            idx_reg      <= MemAdr[ADDR_W+1:2];
            data_reg     <= MemWriteD;
         end
         if (rd_en) rdata_reg <= mem[cur_idx];
      end
   end

`ifdef DMEM_ERR_EN
   always_ff @(posedge clk) begin
      if (rst)               err_reg <= 1'b0;
      else if (idle && req)  err_reg <= req_err;
      else if (!idle && state_next == IDLE) err_reg <= 1'b0;
   end
`endif

   // Array is not reset; a reset on the commit edge still blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) mem[cur_idx] <= cur_data;
   end

endmodule
